// File: rtl/gates_pkg.sv
// Shared definitions for the registered two-input logic gate unit.
package gates_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5,
    GATE_NOTA = 3'd6,
    GATE_BUFA = 3'd7
  } gate_op_e;

  localparam int GATE_NUM_OPS = 8;

endpackage

// File: rtl/gates_if.sv
// Operand/result bundle of gates_core. The driver asserts en_in with operands;
// valid_out answers one cycle later with no backpressure (there is no ready).
interface gates_if #(
  parameter int WIDTH = 1
) ();

  logic                      en_in;
  logic [2:0]                op_in;
  logic [WIDTH-1:0]          a_in;
  logic [WIDTH-1:0]          b_in;
  logic [WIDTH-1:0]          z_out;
  logic                      valid_out;
  logic [8*WIDTH-1:0]        all_out;

  modport master (
    output en_in, op_in, a_in, b_in,
    input  z_out, valid_out, all_out
  );

  modport slave (
    input  en_in, op_in, a_in, b_in,
    output z_out, valid_out, all_out
  );

endinterface

// File: rtl/gate_eval.sv
// Purely combinational bitwise evaluation of one gate operation.
module gate_eval
  import gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  gate_op_e         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z
);

  // NOT/BUF never read b, so an unknown b cannot leak into their results.
  always_comb begin
    z = '0;
    case (op)
      GATE_AND:  z = a & b;
      GATE_OR:   z = a | b;
      GATE_NAND: z = ~(a & b);
      GATE_NOR:  z = ~(a | b);
      GATE_XOR:  z = a ^ b;
      GATE_XNOR: z = ~(a ^ b);
      GATE_NOTA: z = ~a;
      GATE_BUFA: z = a;
      default:   z = '0;
    endcase
  end

endmodule

// File: rtl/gates_core.sv
// Registered logic gate unit: all eight ops evaluated in parallel, the selected
// one and the full set captured when en_in is high.
module gates_core
  import gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic   clk_in,
  input logic   rst_in,
  gates_if.slave bus
);

  logic [WIDTH-1:0]   res [GATE_NUM_OPS];
  logic [8*WIDTH-1:0] all_d, all_q;
  logic [WIDTH-1:0]   z_d, z_q;
  logic               valid_d, valid_q;

  for (genvar k = 0; k < GATE_NUM_OPS; k++) begin : g_op
    gate_eval #(.WIDTH(WIDTH)) u_eval (
      .op (gate_op_e'(k)),
      .a  (bus.a_in),
      .b  (bus.b_in),
      .z  (res[k])
    );
  end

  always_comb begin
    z_d     = z_q;
    all_d   = all_q;
    valid_d = 1'b0;
    if (bus.en_in) begin
      z_d     = res[bus.op_in];
      valid_d = 1'b1;
      for (int k = 0; k < GATE_NUM_OPS; k++) begin
        all_d[k*WIDTH +: WIDTH] = res[k];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      z_q     <= '0;
      all_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      z_q     <= z_d;
      all_q   <= all_d;
      valid_q <= valid_d;
    end
  end

  assign bus.z_out     = z_q;
  assign bus.all_out   = all_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_gates_core.sv
// Directed bench for gates_core at WIDTH=1 and WIDTH=8 with queue scoreboards.
module tb_gates_core;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [8:0]  exp_q1[$];
  logic [71:0] exp_q8[$];

  gates_if #(.WIDTH(1)) bus1 ();
  gates_if #(.WIDTH(8)) bus8 ();

  gates_core #(.WIDTH(1)) dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1));
  gates_core #(.WIDTH(8)) dut8 (.clk_in(clk), .rst_in(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitors: each valid_out pops one expected {z, all} entry.
  always @(negedge clk) begin
    if (bus1.valid_out === 1'b1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w1_unexpected_valid: got z=%h all=%h expected no result", bus1.z_out, bus1.all_out);
      end else begin
        logic [8:0] e;
        e = exp_q1.pop_front();
        check("w1_z", {71'd0, bus1.z_out}, {71'd0, e[8]});
        check("w1_all", {64'd0, bus1.all_out}, {64'd0, e[7:0]});
      end
    end
    if (bus8.valid_out === 1'b1) begin
      if (exp_q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_unexpected_valid: got z=%h all=%h expected no result", bus8.z_out, bus8.all_out);
      end else begin
        logic [71:0] e;
        e = exp_q8.pop_front();
        check("w8_z", {64'd0, bus8.z_out}, {64'd0, e[71:64]});
        check("w8_all", {8'd0, bus8.all_out}, {8'd0, e[63:0]});
      end
    end
  end

  task automatic drive1(input logic en, input logic [2:0] op, input logic a, input logic b,
                        input logic exp_z, input logic [7:0] exp_all);
    bus1.en_in = en;
    bus1.op_in = op;
    bus1.a_in  = a;
    bus1.b_in  = b;
    bus8.en_in = 1'b0;
    if (en && !rst) exp_q1.push_back({exp_z, exp_all});
    @(negedge clk);
  endtask

  task automatic drive8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_z, input logic [63:0] exp_all);
    bus1.en_in = 1'b0;
    bus8.en_in = 1'b1;
    bus8.op_in = op;
    bus8.a_in  = a;
    bus8.b_in  = b;
    if (!rst) exp_q8.push_back({exp_z, exp_all});
    @(negedge clk);
  endtask

  localparam logic [63:0] ALL8 = 64'hF0_0F_A5_5A_05_5F_FA_A0;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus1.en_in = 1'b0; bus1.op_in = 3'd0; bus1.a_in = 1'b0; bus1.b_in = 1'b0;
    bus8.en_in = 1'b0; bus8.op_in = 3'd0; bus8.a_in = 8'h00; bus8.b_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_z", {71'd0, bus1.z_out}, 72'd0);
    check("reset_valid", {71'd0, bus1.valid_out}, 72'd0);
    check("reset_all", {64'd0, bus1.all_out}, 72'd0);
    check("reset_all8", {8'd0, bus8.all_out}, 72'd0);
    rst = 1'b0;

    // Truth table under AND: A,B = 00, 10, 11, 01.
    drive1(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h6C);
    drive1(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h96);
    drive1(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA3);
    drive1(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h56);

    // NOT A with b toggling, then BUF A.
    drive1(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'h96);
    drive1(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'hA3);
    drive1(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 8'hA3);

    // Enable hold.
    drive1(1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA3);
    drive1(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("hold_z", {71'd0, bus1.z_out}, 72'd1);
    check("hold_valid", {71'd0, bus1.valid_out}, 72'd0);
    check("hold_all", {64'd0, bus1.all_out}, 72'hA3);

    // Reset priority over enable.
    rst = 1'b1;
    drive1(1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("rstpri_z", {71'd0, bus1.z_out}, 72'd0);
    check("rstpri_valid", {71'd0, bus1.valid_out}, 72'd0);
    check("rstpri_all", {64'd0, bus1.all_out}, 72'd0);
    rst = 1'b0;

    // Op switching every cycle with a=1, b=0.
    drive1(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h96);
    drive1(1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 8'h96);
    drive1(1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 8'h96);
    drive1(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h96);
    drive1(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 8'h96);
    drive1(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'h96);
    drive1(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'h96);
    drive1(1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 8'h96);

    // WIDTH=8 with a=F0, b=AA over every op.
    drive8(3'd0, 8'hF0, 8'hAA, 8'hA0, ALL8);
    drive8(3'd1, 8'hF0, 8'hAA, 8'hFA, ALL8);
    drive8(3'd2, 8'hF0, 8'hAA, 8'h5F, ALL8);
    drive8(3'd3, 8'hF0, 8'hAA, 8'h05, ALL8);
    drive8(3'd4, 8'hF0, 8'hAA, 8'h5A, ALL8);
    drive8(3'd5, 8'hF0, 8'hAA, 8'hA5, ALL8);
    drive8(3'd6, 8'hF0, 8'hAA, 8'h0F, ALL8);
    drive8(3'd7, 8'hF0, 8'hAA, 8'hF0, ALL8);

    bus1.en_in = 1'b0;
    bus8.en_in = 1'b0;
    repeat (3) @(negedge clk);
    check("w1_queue_drained", {40'd0, 32'(exp_q1.size())}, 72'd0);
    check("w8_queue_drained", {40'd0, 32'(exp_q8.size())}, 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
